// File: rtl/shift_reg_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ser_ctrl
// Purpose  : Word-to-bit serialiser sequencer. Accepts parallel words over a
//            valid/ready handshake, loads them into a shift register and
//            streams them out one bit per accepted beat, MSB- or LSB-first.
//            It can insert optional idle cycles between words, and it counts
//            completed words.
// Ports    : clk        - clock, all state changes on posedge
//            reset_n    - synchronous reset, active-low
//            in_valid   - producer has a word on in_data
//            in_ready   - block can accept a word this cycle
//            in_data    - parallel word (WIDTH bits)
//            msb_first  - bit order, sampled only on the load handshake
//            abort      - synchronous abort of the word in flight
//            ser_ready  - consumer accepts the current bit this cycle
//            ser_valid  - ser_out holds a valid bit
//            ser_out    - current serial bit
//            ser_last   - current bit is the final bit of the word
//            busy       - sequencer is not idle
//            word_cnt   - completed-word counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ser_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    input  logic             abort,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int         CNT_W    = $clog2(WIDTH);
    localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sr;
    logic               r_msb;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic [15:0]        r_word_cnt;

    logic               w_load;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_abort_word;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_beat       = 1'b0;
        w_last_beat  = 1'b0;
        w_abort_word = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort in IDLE suppresses a coincident load
                if (in_valid && !abort) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    // abort beats a coincident last beat: the word is not counted
                    w_abort_word = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (ser_ready) begin
                    w_beat = 1'b1;
                    if (r_bit_cnt == '0) begin
                        w_last_beat = 1'b1;
                        w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_abort_word = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs come from registered state only; reset_n gating forces them
    // low for the whole time reset is held, not just after the first edge.
    always_comb begin
        in_ready  = reset_n && (r_state == S_IDLE);
        ser_valid = reset_n && (r_state == S_SHIFT);
        busy      = reset_n && (r_state != S_IDLE);
        ser_out   = ser_valid && (r_msb ? r_sr[WIDTH-1] : r_sr[0]);
        ser_last  = ser_valid && (r_bit_cnt == '0);
        word_cnt  = r_word_cnt;
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit/gap counters, word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sr       <= '0;
            r_msb      <= 1'b0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= 4'd0;
            r_word_cnt <= 16'd0;
        end else begin
            if (w_load) begin
                r_sr      <= in_data;
                r_msb     <= msb_first;
                r_bit_cnt <= CNT_W'(WIDTH - 1);
            end else if (w_abort_word) begin
                r_sr <= '0;
            end else if (w_beat) begin
                // shift toward the output bit with zero fill
                r_sr      <= r_msb ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end

            if (w_last_beat) begin
                r_word_cnt <= r_word_cnt + 16'd1;
                r_gap_cnt  <= GAP_LOAD;
            end else if (r_state == S_GAP && r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_ser_ctrl
// Purpose  : Self-checking bench for shift_reg_ser_ctrl. Two instances
//            (GAP=0 and GAP=3) share one stimulus stream; a word-level
//            reference model predicts every output of both each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_ser_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, in_valid, msb_first, abort, ser_ready;
    logic [W-1:0] in_data;
    logic         rdy [2];
    logic         sv  [2];
    logic         so  [2];
    logic         sl  [2];
    logic         bz  [2];
    logic [15:0]  wc  [2];

    int checks = 0;
    int errors = 0;

    shift_reg_ser_ctrl #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .msb_first(msb_first), .abort(abort),
        .ser_ready(ser_ready), .ser_valid(sv[0]), .ser_out(so[0]),
        .ser_last(sl[0]), .busy(bz[0]), .word_cnt(wc[0])
    );

    shift_reg_ser_ctrl #(.WIDTH(W), .GAP(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .msb_first(msb_first), .abort(abort),
        .ser_ready(ser_ready), .ser_valid(sv[1]), .ser_out(so[1]),
        .ser_last(sl[1]), .busy(bz[1]), .word_cnt(wc[1])
    );

    // Word-level reference model: the word in flight, how many of its bits
    // have been handed over, remaining idle cycles, and completed words.
    int           gapv   [2] = '{0, 3};
    logic [W-1:0] m_word [2];
    logic         m_msb  [2];
    int           m_sent [2];
    logic         m_act  [2];
    int           m_gap  [2];
    logic [15:0]  m_cnt  [2];

    logic [20:0]  got, want;

    function automatic logic [20:0] exp_vec(int i);
        logic e_act, e_idle, e_out, e_last;
        int   pos;
        e_act  = reset_n && m_act[i];
        e_idle = !m_act[i] && (m_gap[i] == 0);
        pos    = m_msb[i] ? (W - 1 - m_sent[i]) : m_sent[i];
        e_out  = e_act && (((m_word[i] >> pos) & 1) != 0);
        e_last = e_act && (m_sent[i] == W - 1);
        return {reset_n && e_idle, e_act, e_out, e_last, reset_n && !e_idle, m_cnt[i]};
    endfunction

    task automatic drive(logic rn, logic v, logic [W-1:0] d, logic m, logic ab, logic sr);
        reset_n   = rn;
        in_valid  = v;
        in_data   = d;
        msb_first = m;
        abort     = ab;
        ser_ready = sr;
        #1;
    endtask

    // Advance one clock edge and apply the same inputs to the model.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_act[i] = 1'b0; m_gap[i] = 0; m_sent[i] = 0; m_cnt[i] = 16'd0;
            end else if (m_act[i]) begin
                if (abort) begin
                    m_act[i] = 1'b0;
                end else if (ser_ready) begin
                    m_sent[i]++;
                    if (m_sent[i] == W) begin
                        m_act[i] = 1'b0;
                        m_cnt[i] = m_cnt[i] + 16'd1;
                        m_gap[i] = gapv[i];
                    end
                end
            end else if (m_gap[i] > 0) begin
                m_gap[i] = abort ? 0 : m_gap[i] - 1;
            end else if (in_valid && !abort) begin
                m_act[i]  = 1'b1;
                m_word[i] = in_data;
                m_msb[i]  = msb_first;
                m_sent[i] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(c == 3, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < 2; i++) begin
                checks++;
                got  = {rdy[i], sv[i], so[i], sl[i], bz[i], wc[i]};
                want = exp_vec(i);
                if (got !== want) begin
                    errors++;
                    $display("FAIL reset inst%0d c=%0d got rdy/val/out/last/busy=%b cnt=%0d want %b cnt=%0d",
                             i, c, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rdy[0] !== 1'b1 || sv[0] !== 1'b0 || wc[0] !== 16'd0 || wc[1] !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b val=%b cnt0=%0d cnt1=%0d want rdy=1 val=0 cnt=0",
                     rdy[0], sv[0], wc[0], wc[1]);
        end
    endtask

    // A5 MSB-first, C4 LSB-first with msb_first toggling, F0 with backpressure,
    // 3C aborted with bit 4 pending, then 81.
    task automatic test_directed();
        logic [W-1:0] words [5];
        logic         msbs  [5];
        logic [W-1:0] seq;
        words = '{8'hA5, 8'hC4, 8'hF0, 8'h3C, 8'h81};
        msbs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        seq   = 8'hA5;
        for (int w = 0; w < 5; w++) begin
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, c == 0, (c == 0) ? words[w] : W'($urandom),
                      (c == 0) ? msbs[w] : 1'($urandom),
                      (w == 3 && c == 4), !(w == 2 && c >= 3 && c <= 5));
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    got  = {rdy[i], sv[i], so[i], sl[i], bz[i], wc[i]};
                    want = exp_vec(i);
                    if (got !== want) begin
                        errors++;
                        $display("FAIL directed inst%0d w=%0d c=%0d got rdy/val/out/last/busy=%b cnt=%0d want %b cnt=%0d",
                                 i, w, c, got[20:16], got[15:0], want[20:16], want[15:0]);
                    end
                end
                if (w == 0 && c >= 1 && c <= 8) begin
                    checks++;
                    if (so[0] !== seq[8-c] || sl[0] !== (c == 8)) begin
                        errors++;
                        $display("FAIL a5_stream c=%0d got out=%b last=%b want out=%b last=%b",
                                 c, so[0], sl[0], seq[8-c], (c == 8));
                    end
                end
                if (w == 0 && c == 9) begin
                    checks++;
                    if (wc[0] !== 16'd1 || rdy[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL a5_done got cnt=%0d rdy=%b want cnt=1 rdy=1", wc[0], rdy[0]);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        int last [2];
        int per  [2];
        last = '{-1, -1};
        per  = '{W + 1, W + 1 + 3};
        for (int c = 0; c < 50; c++) begin
            drive(1'b1, 1'b1, W'($urandom), 1'($urandom), 1'b0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                got  = {rdy[i], sv[i], so[i], sl[i], bz[i], wc[i]};
                want = exp_vec(i);
                if (got !== want) begin
                    errors++;
                    $display("FAIL b2b inst%0d c=%0d got rdy/val/out/last/busy=%b cnt=%0d want %b cnt=%0d",
                             i, c, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
                if (rdy[i] === 1'b1) begin
                    if (last[i] >= 0) begin
                        checks++;
                        if (c - last[i] != per[i]) begin
                            errors++;
                            $display("FAIL b2b_period inst%0d got %0d want %0d", i, c - last[i], per[i]);
                        end
                    end
                    last[i] = c;
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 99) != 0, 1'($urandom), W'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                got  = {rdy[i], sv[i], so[i], sl[i], bz[i], wc[i]};
                want = exp_vec(i);
                if (got !== want) begin
                    errors++;
                    $display("FAIL random inst%0d c=%0d got rdy/val/out/last/busy=%b cnt=%0d want %b cnt=%0d",
                             i, c, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
            tick();
        end
    endtask

    // Counter wrap from 16'hFFFF, then reset asserted with bit 5 pending.
    task automatic test_wrap_reset();
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        force dut0.r_word_cnt = 16'hFFFF;
        force dut3.r_word_cnt = 16'hFFFF;
        #1;
        release dut0.r_word_cnt;
        release dut3.r_word_cnt;
        m_cnt = '{16'hFFFF, 16'hFFFF};
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, c == 0, 8'h5A, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                got  = {rdy[i], sv[i], so[i], sl[i], bz[i], wc[i]};
                want = exp_vec(i);
                if (got !== want) begin
                    errors++;
                    $display("FAIL wrap inst%0d c=%0d got rdy/val/out/last/busy=%b cnt=%0d want %b cnt=%0d",
                             i, c, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
            tick();
        end
        checks++;
        if (wc[0] !== 16'd0 || wc[1] !== 16'd0) begin
            errors++;
            $display("FAIL wrap_value got cnt0=%0d cnt1=%0d want 0", wc[0], wc[1]);
        end
        for (int c = 0; c < 8; c++) begin
            drive(c != 5, c == 0, 8'hFF, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                got  = {rdy[i], sv[i], so[i], sl[i], bz[i], wc[i]};
                want = exp_vec(i);
                if (got !== want) begin
                    errors++;
                    $display("FAIL midreset inst%0d c=%0d got rdy/val/out/last/busy=%b cnt=%0d want %b cnt=%0d",
                             i, c, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
            if (c == 5) begin
                checks++;
                if ({rdy[0], sv[0], so[0], sl[0], bz[0]} !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_outputs got rdy/val/out/last/busy=%b want 00000",
                             {rdy[0], sv[0], so[0], sl[0], bz[0]});
                end
            end
            if (c == 6) begin
                checks++;
                if (wc[0] !== 16'd0 || sv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL after_reset got cnt=%0d val=%b rdy=%b want cnt=0 val=0 rdy=1",
                             wc[0], sv[0], rdy[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_gap[i] = 0; m_sent[i] = 0; m_cnt[i] = 16'd0;
            m_word[i] = '0; m_msb[i] = 1'b0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
